// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit and the data-cache uop interface.
package lsu_pkg;

    localparam int DC_AW = 5;

    localparam logic [3:0] STR_UOP = 4'b1001;
    localparam logic [3:0] LDR_UOP = 4'b1010;
    localparam logic [3:0] NOP_UOP = 4'b0000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } lsu_state_t;

endpackage

// File: rtl/lsu_agen.sv
// Effective-address generation: base +/- unsigned imm12 (32-bit wrap),
// dcache word index, and misaligned / out-of-range flags.
module lsu_agen
    import lsu_pkg::*;
(
    input  logic [31:0]      base,
    input  logic [11:0]      offset,
    input  logic             up,
    output logic [DC_AW-1:0] word,
    output logic             misaligned,
    output logic             out_of_range
);

    logic [31:0] ea;

    assign ea           = up ? base + {20'd0, offset} : base - {20'd0, offset};
    assign word         = ea[DC_AW+1:2];
    assign misaligned   = |ea[1:0];
    // Anything above the 32-word window, including a wrapped subtract, is a fault.
    assign out_of_range = |ea[31:DC_AW+2];

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one memory uop at a time, drives the data cache
// for one ISSUE cycle and returns load data as a one-cycle writeback pulse.
module lsu
    import lsu_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_uop,
    input  logic [31:0]      in_base,
    input  logic [11:0]      in_offset,
    input  logic             in_up,
    input  logic [31:0]      in_data,
    input  logic [3:0]       in_rd,
    output logic [DC_AW-1:0] dc_addr,
    output logic [31:0]      dc_data_in,
    output logic [3:0]       dc_uop,
    input  logic [31:0]      dc_data_out,
    output logic             wb_valid,
    output logic [3:0]       wb_rd,
    output logic [31:0]      wb_data,
    output logic             fault
);

    lsu_state_t       state;
    logic [DC_AW-1:0] word;
    logic             misaligned;
    logic             out_of_range;
    logic             is_mem;

    lsu_agen u_agen (
        .base         (in_base),
        .offset       (in_offset),
        .up           (in_up),
        .word         (word),
        .misaligned   (misaligned),
        .out_of_range (out_of_range)
    );

    assign is_mem   = (in_uop == STR_UOP) || (in_uop == LDR_UOP);
    assign in_ready = (state == IDLE);

    // NOTE: every register here uses <= so all reads in a cycle see the
    // pre-edge values; reset takes priority, so an accept on the reset edge is lost.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            dc_uop     <= NOP_UOP;
            dc_addr    <= '0;
            dc_data_in <= '0;
            wb_valid   <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= '0;
            fault      <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            fault    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (in_valid && is_mem) begin
                        if (misaligned || out_of_range) begin
                            fault <= 1'b1;
                        end else begin
                            dc_addr <= word;
                            dc_uop  <= in_uop;
                            wb_rd   <= in_rd;
                            if (in_uop == STR_UOP) dc_data_in <= in_data;
                            state   <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    // The dcache samples dc_* at the end of this cycle.
                    dc_uop <= NOP_UOP;
                    state  <= (dc_uop == LDR_UOP) ? CAPTURE : IDLE;
                end
                CAPTURE: begin
                    wb_data  <= dc_data_out;
                    wb_valid <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu with a small behavioural 32-word dcache.
module tb_lsu;
    import lsu_pkg::*;

    logic             clock;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_uop;
    logic [31:0]      in_base;
    logic [11:0]      in_offset;
    logic             in_up;
    logic [31:0]      in_data;
    logic [3:0]       in_rd;
    logic [DC_AW-1:0] dc_addr;
    logic [31:0]      dc_data_in;
    logic [3:0]       dc_uop;
    logic [31:0]      dc_data_out;
    logic             wb_valid;
    logic [3:0]       wb_rd;
    logic [31:0]      wb_data;
    logic             fault;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] IDLE_BUS = 32'hA5A5_A5A5;

    lsu dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_uop      (in_uop),
        .in_base     (in_base),
        .in_offset   (in_offset),
        .in_up       (in_up),
        .in_data     (in_data),
        .in_rd       (in_rd),
        .dc_addr     (dc_addr),
        .dc_data_in  (dc_data_in),
        .dc_uop      (dc_uop),
        .dc_data_out (dc_data_out),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .fault       (fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Dcache stand-in: no reset, registered read data valid for one cycle.
    logic [31:0] mem [32];
    always @(posedge clock) begin
        if (dc_uop == STR_UOP) mem[dc_addr] <= dc_data_in;
        dc_data_out <= (dc_uop == LDR_UOP) ? mem[dc_addr] : IDLE_BUS;
    end

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic offer(input logic [3:0] u, input logic [31:0] b, input logic [11:0] o,
                         input logic up, input logic [31:0] d, input logic [3:0] rd);
        in_valid  = 1'b1;
        in_uop    = u;
        in_base   = b;
        in_offset = o;
        in_up     = up;
        in_data   = d;
        in_rd     = rd;
        tick();
        in_valid  = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({in_ready, dc_uop, dc_addr, dc_data_in, wb_valid, wb_rd, wb_data, fault} !==
            {1'b1, NOP_UOP, 5'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: got rdy=%b uop=%h addr=%0d din=%h wbv=%b rd=%0d wbd=%h flt=%b, required 1/0/0/0/0/0/0/0",
                     in_ready, dc_uop, dc_addr, dc_data_in, wb_valid, wb_rd, wb_data, fault);
        end
    endtask

    task automatic test_str_ldr();
        offer(STR_UOP, 32'h10, 12'd4, 1'b1, 32'hDEAD_BEEF, 4'd0);
        checks++;
        if ({dc_uop, dc_addr, dc_data_in, in_ready} !== {STR_UOP, 5'd5, 32'hDEAD_BEEF, 1'b0}) begin
            errors++;
            $display("FAIL str_issue: got uop=%h addr=%0d din=%h rdy=%b, required 9/5/deadbeef/0",
                     dc_uop, dc_addr, dc_data_in, in_ready);
        end
        tick();
        checks++;
        if ({in_ready, dc_uop} !== {1'b1, NOP_UOP}) begin
            errors++;
            $display("FAIL str_done: got rdy=%b uop=%h, required 1/0", in_ready, dc_uop);
        end
        offer(LDR_UOP, 32'h10, 12'd4, 1'b1, 32'h0, 4'd3);
        checks++;
        if ({dc_uop, dc_addr} !== {LDR_UOP, 5'd5}) begin
            errors++;
            $display("FAIL ldr_issue: got uop=%h addr=%0d, required a/5", dc_uop, dc_addr);
        end
        tick();
        checks++;
        if ({wb_valid, in_ready, dc_uop} !== {1'b0, 1'b0, NOP_UOP}) begin
            errors++;
            $display("FAIL ldr_capture: got wbv=%b rdy=%b uop=%h, required 0/0/0", wb_valid, in_ready, dc_uop);
        end
        tick();
        checks++;
        if ({wb_valid, wb_rd, wb_data, in_ready} !== {1'b1, 4'd3, 32'hDEAD_BEEF, 1'b1}) begin
            errors++;
            $display("FAIL ldr_wb: got wbv=%b rd=%0d data=%h rdy=%b, required 1/3/deadbeef/1",
                     wb_valid, wb_rd, wb_data, in_ready);
        end
        tick();
        checks++;
        if (wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL ldr_wb_pulse: got wbv=%b, required 0", wb_valid);
        end
    endtask

    task automatic test_ldr_down();
        offer(STR_UOP, 32'h18, 12'd0, 1'b1, 32'h1234_5678, 4'd0);
        tick();
        offer(LDR_UOP, 32'h20, 12'd8, 1'b0, 32'h0, 4'd7);
        checks++;
        if ({dc_uop, dc_addr} !== {LDR_UOP, 5'd6}) begin
            errors++;
            $display("FAIL ldr_down_issue: got uop=%h addr=%0d, required a/6", dc_uop, dc_addr);
        end
        tick();
        tick();
        checks++;
        if ({wb_valid, wb_rd, wb_data} !== {1'b1, 4'd7, 32'h1234_5678}) begin
            errors++;
            $display("FAIL ldr_down_wb: got wbv=%b rd=%0d data=%h, required 1/7/12345678",
                     wb_valid, wb_rd, wb_data);
        end
        tick();
    endtask

    task automatic test_fault();
        offer(LDR_UOP, 32'h12, 12'd0, 1'b1, 32'h0, 4'd2);
        checks++;
        if ({fault, dc_uop, in_ready, wb_valid} !== {1'b1, NOP_UOP, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL fault_misaligned: got flt=%b uop=%h rdy=%b wbv=%b, required 1/0/1/0",
                     fault, dc_uop, in_ready, wb_valid);
        end
        tick();
        checks++;
        if ({fault, wb_valid, dc_uop} !== {1'b0, 1'b0, NOP_UOP}) begin
            errors++;
            $display("FAIL fault_pulse: got flt=%b wbv=%b uop=%h, required 0/0/0", fault, wb_valid, dc_uop);
        end
        offer(STR_UOP, 32'h80, 12'd0, 1'b1, 32'h5555_5555, 4'd0);
        checks++;
        if ({fault, dc_uop, in_ready} !== {1'b1, NOP_UOP, 1'b1}) begin
            errors++;
            $display("FAIL fault_range: got flt=%b uop=%h rdy=%b, required 1/0/1", fault, dc_uop, in_ready);
        end
        offer(LDR_UOP, 32'h0, 12'd4, 1'b0, 32'h0, 4'd2);
        checks++;
        if ({fault, dc_uop} !== {1'b1, NOP_UOP}) begin
            errors++;
            $display("FAIL fault_sub_wrap: got flt=%b uop=%h, required 1/0", fault, dc_uop);
        end
        offer(STR_UOP, 32'hFFFF_FFFC, 12'd4, 1'b1, 32'h0BAD_F00D, 4'd0);
        checks++;
        if ({fault, dc_uop, dc_addr} !== {1'b0, STR_UOP, 5'd0}) begin
            errors++;
            $display("FAIL add_wrap_word0: got flt=%b uop=%h addr=%0d, required 0/9/0", fault, dc_uop, dc_addr);
        end
        tick();
        offer(STR_UOP, 32'h7C, 12'd0, 1'b1, 32'h3131_3131, 4'd0);
        checks++;
        if ({fault, dc_uop, dc_addr} !== {1'b0, STR_UOP, 5'd31}) begin
            errors++;
            $display("FAIL top_word31: got flt=%b uop=%h addr=%0d, required 0/9/31", fault, dc_uop, dc_addr);
        end
        tick();
    endtask

    task automatic test_drop();
        offer(4'b0011, 32'h12, 12'd0, 1'b1, 32'h0, 4'd1);
        checks++;
        if ({fault, dc_uop, in_ready, wb_valid} !== {1'b0, NOP_UOP, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL drop_other_uop: got flt=%b uop=%h rdy=%b wbv=%b, required 0/0/1/0",
                     fault, dc_uop, in_ready, wb_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  u [3];
        logic [31:0] b [3];
        logic [31:0] d [3];
        logic [7:0]  exp_ready;
        logic [7:0]  exp_wb;
        int          idx;
        u = '{STR_UOP, STR_UOP, LDR_UOP};
        b = '{32'h20, 32'h24, 32'h20};
        d = '{32'h1111_2222, 32'h3333_4444, 32'h0};
        exp_ready = 8'b1001_0101;
        exp_wb    = 8'b1000_0000;
        idx = 0;
        for (int k = 0; k < 8; k++) begin
            if (idx < 3) begin
                in_valid  = 1'b1;
                in_uop    = u[idx];
                in_base   = b[idx];
                in_offset = 12'd0;
                in_up     = 1'b1;
                in_data   = d[idx];
                in_rd     = 4'd5;
            end else begin
                in_valid  = 1'b0;
            end
            checks++;
            if (in_ready !== exp_ready[k]) begin
                errors++;
                $display("FAIL b2b_ready cycle %0d: got %b, required %b", k, in_ready, exp_ready[k]);
            end
            checks++;
            if (wb_valid !== exp_wb[k]) begin
                errors++;
                $display("FAIL b2b_wb_valid cycle %0d: got %b, required %b", k, wb_valid, exp_wb[k]);
            end
            if (exp_wb[k]) begin
                checks++;
                if ({wb_rd, wb_data} !== {4'd5, 32'h1111_2222}) begin
                    errors++;
                    $display("FAIL b2b_wb_data: got rd=%0d data=%h, required 5/11112222", wb_rd, wb_data);
                end
            end
            if (exp_ready[k]) idx++;
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_capture();
        offer(LDR_UOP, 32'h14, 12'd0, 1'b1, 32'h0, 4'd4);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({wb_valid, in_ready, dc_uop} !== {1'b0, 1'b1, NOP_UOP}) begin
            errors++;
            $display("FAIL reset_in_capture: got wbv=%b rdy=%b uop=%h, required 0/1/0", wb_valid, in_ready, dc_uop);
        end
        tick();
        checks++;
        if (wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_capture_late_wb: got wbv=%b, required 0", wb_valid);
        end
    endtask

    task automatic test_reset_issue();
        offer(STR_UOP, 32'h28, 12'd0, 1'b1, 32'hA1B2_C3D4, 4'd0);
        reset = 1'b1;
        tick();
        // Reset still held: an op offered on this edge must be ignored.
        in_valid  = 1'b1;
        in_uop    = LDR_UOP;
        in_base   = 32'h28;
        in_offset = 12'd0;
        in_up     = 1'b1;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if ({in_ready, dc_uop} !== {1'b1, NOP_UOP}) begin
            errors++;
            $display("FAIL reset_edge_accept: got rdy=%b uop=%h, required 1/0", in_ready, dc_uop);
        end
        offer(LDR_UOP, 32'h28, 12'd0, 1'b1, 32'h0, 4'd9);
        tick();
        tick();
        checks++;
        if ({wb_valid, wb_rd, wb_data} !== {1'b1, 4'd9, 32'hA1B2_C3D4}) begin
            errors++;
            $display("FAIL reset_in_issue_store: got wbv=%b rd=%0d data=%h, required 1/9/a1b2c3d4",
                     wb_valid, wb_rd, wb_data);
        end
        tick();
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_uop    = NOP_UOP;
        in_base   = '0;
        in_offset = '0;
        in_up     = 1'b1;
        in_data   = '0;
        in_rd     = '0;
        @(negedge clock);
        tick();
        tick();
        test_reset();
        reset = 1'b0;
        tick();
        test_str_ldr();
        test_ldr_down();
        test_fault();
        test_drop();
        test_back_to_back();
        test_reset_capture();
        test_reset_issue();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
